// File: rtl/eth_pkg.sv
// Shared state type, framing constants and the CRC-32 byte step for the Ethernet TX MAC.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Reflected CRC-32 advanced by one byte, byte LSB consumed first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide CRC-32 register: init reloads the seed, en folds in one data byte per clock.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc32_d8(crc, data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC32_INIT;
    end else if (init) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/eth_tx_mac.sv
// Transmit MAC: 32-bit word stream to GMII bytes with preamble/SFD, optional pad, FCS and IFG.
// Build option ETH_TX_PAD_EN enables zero padding of short frames up to MIN_FRAME bytes.
module eth_tx_mac
  import eth_pkg::*;
#(
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_vld,
  input  logic        i_sop,
  input  logic        i_eop,
  output logic        o_rdy,
  output logic [7:0]  o_txd,
  output logic        o_txen,
  output logic        o_err
);

  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
`endif

  tx_state_t   state, state_n;
  logic [23:0] hold, hold_n;
  logic [1:0]  left, left_n;
  logic        eop_l, eop_n;
  logic [10:0] cnt, cnt_n, cnt_inc;
  logic [15:0] step, step_n;
  logic [7:0]  txd_n;
  logic        txen_n, err_n, rdy;
  logic        crc_init, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc, fcs;

  eth_crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_din),
    .crc  (crc)
  );

  assign fcs     = ~crc;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 11'd1;
  assign o_rdy   = rdy & ~rst;

  // Outputs are registered, so each branch chooses the byte for the next cycle;
  // the CRC is fed that same byte, making it complete when FCS starts.
  always_comb begin
    state_n  = state;
    hold_n   = hold;
    left_n   = left;
    eop_n    = eop_l;
    cnt_n    = cnt;
    step_n   = step;
    txd_n    = o_txd;
    txen_n   = o_txen;
    err_n    = 1'b0;
    rdy      = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_din  = 8'h00;

    case (state)
      ST_IDLE: begin
        rdy      = 1'b1;
        txd_n    = 8'h00;
        txen_n   = 1'b0;
        crc_init = 1'b1;
        if (i_vld && i_sop) begin
          state_n = ST_PRE;
          txd_n   = ETH_PREAMBLE;
          txen_n  = 1'b1;
          hold_n  = {i_data[15:0], 8'h00};
          eop_n   = i_eop;
          cnt_n   = '0;
          step_n  = '0;
        end
      end

      ST_PRE: begin
        if (step == 16'd7) begin
          state_n = ST_DATA;
          txd_n   = hold[23:16];
          hold_n  = {hold[15:0], 8'h00};
          left_n  = 2'd1;
          cnt_n   = cnt_inc;
          crc_en  = 1'b1;
          crc_din = hold[23:16];
        end else begin
          txd_n  = (step == 16'd6) ? ETH_SFD : ETH_PREAMBLE;
          step_n = step + 16'd1;
        end
      end

      ST_DATA: begin
        if (left != 2'd0) begin
          txd_n   = hold[23:16];
          hold_n  = {hold[15:0], 8'h00};
          left_n  = left - 2'd1;
          cnt_n   = cnt_inc;
          crc_en  = 1'b1;
          crc_din = hold[23:16];
        end else if (eop_l) begin
`ifdef ETH_TX_PAD_EN
          if (cnt < MIN_CNT) begin
            state_n = ST_PAD;
            txd_n   = 8'h00;
            cnt_n   = cnt_inc;
            crc_en  = 1'b1;
          end else begin
            state_n = ST_FCS;
            txd_n   = fcs[7:0];
            step_n  = '0;
          end
`else
          state_n = ST_FCS;
          txd_n   = fcs[7:0];
          step_n  = '0;
`endif
        end else begin
          rdy = 1'b1;
          if (i_vld && !i_sop) begin
            txd_n   = i_data[31:24];
            hold_n  = i_data[23:0];
            left_n  = 2'd3;
            eop_n   = i_eop;
            cnt_n   = cnt_inc;
            crc_en  = 1'b1;
            crc_din = i_data[31:24];
          end else begin
            state_n = ST_IFG;
            err_n   = 1'b1;
            txen_n  = 1'b0;
            txd_n   = 8'h00;
            step_n  = '0;
          end
        end
      end

`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        if (cnt >= MIN_CNT) begin
          state_n = ST_FCS;
          txd_n   = fcs[7:0];
          step_n  = '0;
        end else begin
          txd_n  = 8'h00;
          cnt_n  = cnt_inc;
          crc_en = 1'b1;
        end
      end
`endif

      ST_FCS: begin
        if (step[1:0] == 2'd3) begin
          state_n = ST_IFG;
          txd_n   = 8'h00;
          txen_n  = 1'b0;
          step_n  = '0;
        end else begin
          case (step[1:0])
            2'd0:    txd_n = fcs[15:8];
            2'd1:    txd_n = fcs[23:16];
            default: txd_n = fcs[31:24];
          endcase
          step_n = step + 16'd1;
        end
      end

      ST_IFG: begin
        txd_n  = 8'h00;
        txen_n = 1'b0;
        if (step == IFG_LAST) begin
          state_n = ST_IDLE;
        end else begin
          step_n = step + 16'd1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        txd_n   = 8'h00;
        txen_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      hold   <= '0;
      left   <= '0;
      eop_l  <= 1'b0;
      cnt    <= '0;
      step   <= '0;
      o_txd  <= '0;
      o_txen <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      left   <= left_n;
      eop_l  <= eop_n;
      cnt    <= cnt_n;
      step   <= step_n;
      o_txd  <= txd_n;
      o_txen <= txen_n;
      o_err  <= err_n;
    end
  end

endmodule
